// File: rtl/wb_ram_arbiter.sv
// Two-port Wishbone B4 pipelined front end for a single-port DFFRAM macro.
// One access reaches the RAM per cycle; acks and read data return one cycle after accept.
module wb_ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic                wb_clk,
  input  logic                wb_reset_n,
  input  logic                pA_cyc_i,
  input  logic                pA_stb_i,
  input  logic                pA_we_i,
  input  logic [DATA_W/8-1:0] pA_sel_i,
  input  logic [31:0]         pA_adr_i,
  input  logic [DATA_W-1:0]   pA_dat_i,
  output logic                pA_stall_o,
  output logic                pA_ack_o,
  output logic [DATA_W-1:0]   pA_dat_o,
  input  logic                pB_cyc_i,
  input  logic                pB_stb_i,
  input  logic                pB_we_i,
  input  logic [DATA_W/8-1:0] pB_sel_i,
  input  logic [31:0]         pB_adr_i,
  input  logic [DATA_W-1:0]   pB_dat_i,
  output logic                pB_stall_o,
  output logic                pB_ack_o,
  output logic [DATA_W-1:0]   pB_dat_o,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_di,
  input  logic [DATA_W-1:0]   ram_do
);

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

  pri_e state_q, state_d;
  logic reqA, reqB, grantA, grantB;
  logic ackA_q, ackB_q, rdA_q, rdB_q;
  logic unused_adr;

  assign reqA = pA_cyc_i & pA_stb_i;
  assign reqB = pB_cyc_i & pB_stb_i;

  // The state only matters when both ports request in the same cycle.
  assign grantA = reqA & (~reqB | (state_q == PRI_A));
  assign grantB = reqB & ~grantA;

  assign pA_stall_o = reqA & ~grantA;
  assign pB_stall_o = reqB & ~grantB;

  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      state_q <= PRI_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (FIXED_PRI != 0) begin
      state_d = PRI_A;
    end else if (grantA) begin
      state_d = PRI_B;
    end else if (grantB) begin
      state_d = PRI_A;
    end
  end

  // RAM pins are zeroed on idle cycles so the macro sees a quiet bus.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_di   = '0;
    if (grantA) begin
      ram_en   = 1'b1;
      ram_we   = pA_we_i ? pA_sel_i : '0;
      ram_addr = pA_adr_i[ADDR_W+1:2];
      ram_di   = pA_dat_i;
    end else if (grantB) begin
      ram_en   = 1'b1;
      ram_we   = pB_we_i ? pB_sel_i : '0;
      ram_addr = pB_adr_i[ADDR_W+1:2];
      ram_di   = pB_dat_i;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      ackA_q <= 1'b0;
      ackB_q <= 1'b0;
      rdA_q  <= 1'b0;
      rdB_q  <= 1'b0;
    end else begin
      ackA_q <= grantA;
      ackB_q <= grantB;
      rdA_q  <= grantA & ~pA_we_i;
      rdB_q  <= grantB & ~pB_we_i;
    end
  end

  // A master that dropped cyc gets neither the ack nor the data.
  assign pA_ack_o = ackA_q & pA_cyc_i;
  assign pB_ack_o = ackB_q & pB_cyc_i;
  assign pA_dat_o = (pA_ack_o & rdA_q) ? ram_do : '0;
  assign pB_dat_o = (pB_ack_o & rdB_q) ? ram_do : '0;

  assign unused_adr = ^{pA_adr_i[31:ADDR_W+2], pA_adr_i[1:0],
                        pB_adr_i[31:ADDR_W+2], pB_adr_i[1:0]};

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: a round-robin instance with a RAM model,
// plus a fixed-priority instance sharing the same port stimulus.
module tb_wb_ram_arbiter;

  logic        wbClk;
  logic        wbResetN;
  logic        aCyc, aStb, aWe, bCyc, bStb, bWe;
  logic [3:0]  aSel, bSel;
  logic [31:0] aAdr, aDat, bAdr, bDat;

  logic        rrAStall, rrAAck, rrBStall, rrBAck, rrEn;
  logic [31:0] rrADat, rrBDat, rrDi, rrDo;
  logic [3:0]  rrWe;
  logic [7:0]  rrAddr;

  logic        fxAStall, fxAAck, fxBStall, fxBAck, fxEn;
  logic [31:0] fxADat, fxBDat, fxDi;
  logic [3:0]  fxWe;
  logic [7:0]  fxAddr;

  logic [31:0] mem [256];
  int compareCount;
  int mismatchCount;
  int ackCntA;
  int ackCntB;

  wb_ram_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRI(0)) dutRr (
    .wb_clk(wbClk), .wb_reset_n(wbResetN),
    .pA_cyc_i(aCyc), .pA_stb_i(aStb), .pA_we_i(aWe), .pA_sel_i(aSel),
    .pA_adr_i(aAdr), .pA_dat_i(aDat), .pA_stall_o(rrAStall), .pA_ack_o(rrAAck),
    .pA_dat_o(rrADat),
    .pB_cyc_i(bCyc), .pB_stb_i(bStb), .pB_we_i(bWe), .pB_sel_i(bSel),
    .pB_adr_i(bAdr), .pB_dat_i(bDat), .pB_stall_o(rrBStall), .pB_ack_o(rrBAck),
    .pB_dat_o(rrBDat),
    .ram_en(rrEn), .ram_we(rrWe), .ram_addr(rrAddr), .ram_di(rrDi), .ram_do(rrDo)
  );

  wb_ram_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRI(1)) dutFx (
    .wb_clk(wbClk), .wb_reset_n(wbResetN),
    .pA_cyc_i(aCyc), .pA_stb_i(aStb), .pA_we_i(aWe), .pA_sel_i(aSel),
    .pA_adr_i(aAdr), .pA_dat_i(aDat), .pA_stall_o(fxAStall), .pA_ack_o(fxAAck),
    .pA_dat_o(fxADat),
    .pB_cyc_i(bCyc), .pB_stb_i(bStb), .pB_we_i(bWe), .pB_sel_i(bSel),
    .pB_adr_i(bAdr), .pB_dat_i(bDat), .pB_stall_o(fxBStall), .pB_ack_o(fxBAck),
    .pB_dat_o(fxBDat),
    .ram_en(fxEn), .ram_we(fxWe), .ram_addr(fxAddr), .ram_di(fxDi), .ram_do(32'h0)
  );

  initial wbClk = 1'b0;
  always #5 wbClk = ~wbClk;

  // Behavioural DFFRAM256x32: byte-masked write, registered read on a non-write enable.
  always @(posedge wbClk) begin
    if (rrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (rrWe[b]) mem[rrAddr][b*8 +: 8] <= rrDi[b*8 +: 8];
      end
      if (rrWe == 4'h0) rrDo <= mem[rrAddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulusA(input logic cyc, input logic stb, input logic we,
                                input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat);
    aCyc = cyc; aStb = stb; aWe = we; aSel = sel; aAdr = adr; aDat = dat;
  endtask

  task automatic applyStimulusB(input logic cyc, input logic stb, input logic we,
                                input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat);
    bCyc = cyc; bStb = stb; bWe = we; bSel = sel; bAdr = adr; bDat = dat;
  endtask

  task automatic stepCycle;
    @(posedge wbClk);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    ackCntA       = 0;
    ackCntB       = 0;
    rrDo          = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    wbResetN = 1'b0;
    applyStimulusA(0, 0, 0, 4'h0, 32'h0, 32'h0);
    applyStimulusB(0, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) stepCycle();

    @(negedge wbClk);
    checkOutput("rstAckA", rrAAck, 0);
    checkOutput("rstDatA", rrADat, 0);
    checkOutput("rstRamEn", rrEn, 0);
    #1 wbResetN = 1'b1;
    stepCycle();

    // Lone A: write then read back through an aliased address.
    applyStimulusA(1, 1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge wbClk);
    checkOutput("wrStallA", rrAStall, 0);
    checkOutput("wrRamEn", rrEn, 1);
    checkOutput("wrRamWe", rrWe, 4'hF);
    checkOutput("wrRamAddr", rrAddr, 8'h04);
    checkOutput("wrRamDi", rrDi, 32'hDEAD_BEEF);
    stepCycle();
    applyStimulusA(1, 1, 0, 4'hF, 32'hFFFF_F013, 32'h0);
    @(negedge wbClk);
    checkOutput("wrAckA", rrAAck, 1);
    checkOutput("wrAckDatA", rrADat, 0);
    checkOutput("rdRamWe", rrWe, 4'h0);
    checkOutput("rdRamAddrAlias", rrAddr, 8'h04);
    checkOutput("rdStallA", rrAStall, 0);
    stepCycle();
    applyStimulusA(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge wbClk);
    checkOutput("rdAckA", rrAAck, 1);
    checkOutput("rdDatA", rrADat, 32'hDEAD_BEEF);
    checkOutput("idleRamEn", rrEn, 0);
    checkOutput("idleRamAddr", rrAddr, 0);
    checkOutput("idleRamDi", rrDi, 0);
    checkOutput("idleAckB", rrBAck, 0);
    stepCycle();
    @(negedge wbClk);
    checkOutput("ackOneCycleA", rrAAck, 0);
    checkOutput("noAckDatA", rrADat, 0);
    stepCycle();

    // Byte lanes: full write, byte-0 write, readback.
    applyStimulusA(1, 1, 1, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF);
    stepCycle();
    applyStimulusA(1, 1, 1, 4'h1, 32'h0000_0020, 32'h0000_0012);
    @(negedge wbClk);
    checkOutput("laneRamWe", rrWe, 4'h1);
    checkOutput("laneRamAddr", rrAddr, 8'h08);
    stepCycle();
    applyStimulusA(1, 1, 0, 4'hF, 32'h0000_0020, 32'h0);
    stepCycle();
    applyStimulusA(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge wbClk);
    checkOutput("laneAckA", rrAAck, 1);
    checkOutput("laneDatA", rrADat, 32'hFFFF_FF12);
    stepCycle();

    // Reset while a read ack is pending; priority also returns to A.
    applyStimulusA(1, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
    stepCycle();
    applyStimulusA(1, 0, 0, 4'h0, 32'h0, 32'h0);
    wbResetN = 1'b0;
    @(negedge wbClk);
    checkOutput("midRstAckA", rrAAck, 0);
    checkOutput("midRstDatA", rrADat, 0);
    checkOutput("midRstRamEn", rrEn, 0);
    #1 wbResetN = 1'b1;
    stepCycle();

    // Contention: both ports read every cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulusA(1, 1, 0, 4'hF, 32'(i * 4), 32'h0);
      applyStimulusB(1, 1, 0, 4'hF, 32'(32'h100 + i * 4), 32'h0);
      @(negedge wbClk);
      checkOutput($sformatf("rrStallA%0d", i), rrAStall, 32'(i % 2));
      checkOutput($sformatf("rrStallB%0d", i), rrBStall, 32'((i + 1) % 2));
      checkOutput($sformatf("fxStallA%0d", i), fxAStall, 0);
      checkOutput($sformatf("fxStallB%0d", i), fxBStall, 1);
      checkOutput($sformatf("ackExcl%0d", i), rrAAck & rrBAck, 0);
      if (i > 0) begin
        if (rrAAck === 1'b1) ackCntA++;
        if (rrBAck === 1'b1) ackCntB++;
      end
      stepCycle();
    end
    applyStimulusA(1, 0, 0, 4'h0, 32'h0, 32'h0);
    applyStimulusB(1, 1, 0, 4'hF, 32'h0000_0140, 32'h0);
    @(negedge wbClk);
    if (rrAAck === 1'b1) ackCntA++;
    if (rrBAck === 1'b1) ackCntB++;
    checkOutput("rrAckCountA", ackCntA, 4);
    checkOutput("rrAckCountB", ackCntB, 4);
    checkOutput("fxStallBFree", fxBStall, 0);
    checkOutput("fxRamEnB", fxEn, 1);
    checkOutput("fxRamAddrB", fxAddr, 8'h50);
    stepCycle();
    applyStimulusB(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge wbClk);
    checkOutput("fxAckB", fxBAck, 1);
    checkOutput("rrAckB", rrBAck, 1);
    stepCycle();

    // A drops cyc right after its read is accepted; B proceeds normally.
    applyStimulusA(1, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
    stepCycle();
    applyStimulusA(0, 0, 0, 4'h0, 32'h0, 32'h0);
    applyStimulusB(1, 1, 0, 4'hF, 32'h0000_0020, 32'h0);
    @(negedge wbClk);
    checkOutput("dropAckA", rrAAck, 0);
    checkOutput("dropDatA", rrADat, 0);
    checkOutput("dropStallB", rrBStall, 0);
    checkOutput("dropRamAddrB", rrAddr, 8'h08);
    stepCycle();
    applyStimulusB(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge wbClk);
    checkOutput("dropAckB", rrBAck, 1);
    checkOutput("dropDatB", rrBDat, 32'hFFFF_FF12);
    checkOutput("dropAckAStill", rrAAck, 0);
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
